// File: rtl/sprite_blitter_if.sv
// sprite_blitter_if
// Groups the draw-request handshake, the image ROM read port and the
// vga_adapter pixel port of the sprite blitter.
//   start/img_sel/x0/y0/width/height : draw request from the animation FSM
//   rom_addr/rom_sel/rom_q           : image ROM read port (rom_q returns data)
//   vga_x/vga_y/vga_colour/plot      : pixel write port to vga_adapter
//   busy/done                        : draw status back to the requester
// modport master: the requester / ROM / vga side.
// modport slave : the blitter itself.
interface sprite_blitter_if;
    logic        start;
    logic [1:0]  img_sel;
    logic [8:0]  x0;
    logic [7:0]  y0;
    logic [8:0]  width;
    logic [7:0]  height;
    logic [15:0] rom_addr;
    logic [1:0]  rom_sel;
    logic [2:0]  rom_q;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        plot;
    logic        busy;
    logic        done;

    modport master (
        output start, img_sel, x0, y0, width, height, rom_q,
        input  rom_addr, rom_sel, vga_x, vga_y, vga_colour, plot, busy, done
    );

    modport slave (
        input  start, img_sel, x0, y0, width, height, rom_q,
        output rom_addr, rom_sel, vga_x, vga_y, vga_colour, plot, busy, done
    );
endinterface

// File: rtl/sprite_blitter.sv
// sprite_blitter
// Copies a width x height sprite from the selected image ROM into the
// vga_adapter frame buffer at origin (x0,y0), one pixel per clock.
// Pixels matching the transparent colour key or falling off-screen are
// walked through the pipeline but not plotted.
// Ports:
//   CLOCK_50 : system clock
//   reset    : synchronous, active-low reset
//   bus      : sprite_blitter_if.slave (request, ROM port, pixel port, status)
//
// state | meaning
// IDLE  | waiting for start; request fields latched when start is accepted
// FETCH | one ROM address per clock, row-major over the sprite
// DRAIN | last address issued; waiting for the ROM/pixel pipe to empty
// DONE  | one-cycle done pulse
module sprite_blitter #(
    parameter int         ROM_LATENCY   = 1,
    parameter bit         TRANSP_EN     = 1'b1,
    parameter logic [2:0] TRANSP_COLOUR = 3'b000,
    parameter int         SCREEN_W      = 320,
    parameter int         SCREEN_H      = 240
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    sprite_blitter_if.slave   bus
);

    localparam logic [9:0] SCREEN_W_L = 10'(SCREEN_W);
    localparam logic [8:0] SCREEN_H_L = 9'(SCREEN_H);
    localparam logic [1:0] DRAIN_LOAD = 2'(ROM_LATENCY);

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;
    state_t state, state_nxt;

    logic [8:0]  x0_l, width_l, col;
    logic [7:0]  y0_l, height_l, row;
    logic [15:0] rom_addr_r;
    logic [1:0]  rom_sel_r;
    logic [1:0]  drain_cnt;
    logic        accept, size_zero, last_addr;
    logic        busy_c, done_c;

    // col/row/valid travel alongside the ROM access so they meet rom_q
    logic        pipe_valid [ROM_LATENCY];
    logic [8:0]  pipe_col   [ROM_LATENCY];
    logic [7:0]  pipe_row   [ROM_LATENCY];

    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic        pix_show;

    logic [8:0]  vga_x_r;
    logic [7:0]  vga_y_r;
    logic [2:0]  vga_colour_r;
    logic        plot_r;

    assign accept    = (state == IDLE) && bus.start;
    assign size_zero = (bus.width == 9'd0) || (bus.height == 8'd0);
    assign last_addr = (col == width_l - 9'd1) && (row == height_l - 8'd1);

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_c    = 1'b0;
        done_c    = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_nxt = size_zero ? DONE : FETCH;
                end
            end
            FETCH: begin
                busy_c = 1'b1;
                if (last_addr) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                busy_c = 1'b1;
                if (drain_cnt == 2'd0) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                busy_c    = 1'b1;
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // rom_sel deliberately survives reset so the external ROM mux keeps
    // pointing at the last image
    always_ff @(posedge CLOCK_50) begin
        if (reset && accept) begin
            rom_sel_r <= bus.img_sel;
        end
    end

    assign pix_x    = {1'b0, x0_l} + {1'b0, pipe_col[ROM_LATENCY-1]};
    assign pix_y    = {1'b0, y0_l} + {1'b0, pipe_row[ROM_LATENCY-1]};
    assign pix_show = pipe_valid[ROM_LATENCY-1]
                      && (pix_x < SCREEN_W_L)
                      && (pix_y < SCREEN_H_L)
                      && !(TRANSP_EN && (bus.rom_q == TRANSP_COLOUR));

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            x0_l         <= '0;
            y0_l         <= '0;
            width_l      <= '0;
            height_l     <= '0;
            col          <= '0;
            row          <= '0;
            rom_addr_r   <= '0;
            drain_cnt    <= '0;
            vga_x_r      <= '0;
            vga_y_r      <= '0;
            vga_colour_r <= '0;
            plot_r       <= 1'b0;
            for (int i = 0; i < ROM_LATENCY; i++) begin
                pipe_valid[i] <= 1'b0;
                pipe_col[i]   <= '0;
                pipe_row[i]   <= '0;
            end
        end else begin
            if (accept) begin
                x0_l     <= bus.x0;
                y0_l     <= bus.y0;
                width_l  <= bus.width;
                height_l <= bus.height;
            end

            // rom_addr is a plain incrementing counter: row-major order makes
            // row*width+col equal to the number of addresses already issued
            if (accept && !size_zero) begin
                rom_addr_r <= '0;
                col        <= '0;
                row        <= '0;
            end else if (state == FETCH && !last_addr) begin
                rom_addr_r <= rom_addr_r + 16'd1;
                if (col == width_l - 9'd1) begin
                    col <= '0;
                    row <= row + 8'd1;
                end else begin
                    col <= col + 9'd1;
                end
            end

            // DRAIN lasts ROM_LATENCY+1 cycles so done lands right after the
            // last possible plot
            if (state == FETCH) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (state == DRAIN && drain_cnt != 2'd0) begin
                drain_cnt <= drain_cnt - 2'd1;
            end

            pipe_valid[0] <= (state == FETCH);
            pipe_col[0]   <= col;
            pipe_row[0]   <= row;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
                pipe_col[i]   <= pipe_col[i-1];
                pipe_row[i]   <= pipe_row[i-1];
            end

            vga_x_r      <= pix_x[8:0];
            vga_y_r      <= pix_y[7:0];
            vga_colour_r <= bus.rom_q;
            plot_r       <= pix_show;
        end
    end

    assign bus.rom_addr   = rom_addr_r;
    assign bus.rom_sel    = rom_sel_r;
    assign bus.vga_x      = vga_x_r;
    assign bus.vga_y      = vga_y_r;
    assign bus.vga_colour = vga_colour_r;
    assign bus.plot       = plot_r;
    assign bus.busy       = busy_c;
    assign bus.done       = done_c;

endmodule

// File: doc/sprite_blitter.md
Name: sprite_blitter

Overview:
- Copies one rectangular sprite from a selected image ROM into the vga_adapter frame buffer at an arbitrary (x0,y0) origin, one pixel per clock.
- Sits between the animation control FSM and vga_adapter; replaces the full-screen raster sweep with sized, positioned draws.
- Handles ROM read latency, transparent-colour skipping and off-screen clipping.
- Uses a start/busy/done handshake.

Parameters:
- ROM_LATENCY, 1, clocks from rom_addr change to valid rom_q (legal values 1 or 2)
- TRANSP_EN, 1, 1 = pixels equal to TRANSP_COLOUR are not plotted
- TRANSP_COLOUR, 3'b000, colour key for transparency
- SCREEN_W, 320, visible width; pixels with x >= SCREEN_W are clipped
- SCREEN_H, 240, visible height; pixels with y >= SCREEN_H are clipped

Ports:
- CLOCK_50  in  1  system clock
- reset  in  1  synchronous, active-low reset
- start  in  1  draw request, sampled only in IDLE
- img_sel  in  2  ROM select, latched at start
- x0  in  9  sprite origin x, latched at start
- y0  in  8  sprite origin y, latched at start
- width  in  9  sprite width in pixels, latched at start
- height  in  8  sprite height in pixels, latched at start
- rom_addr  out  16  ROM read address, registered
- rom_sel  out  2  latched img_sel; drives the external ROM mux
- rom_q  in  3  ROM colour data
- vga_x  out  9  pixel x to vga_adapter
- vga_y  out  8  pixel y to vga_adapter
- vga_colour  out  3  pixel colour
- plot  out  1  write strobe, one cycle per pixel
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse at completion

Behaviour:
- Reset (reset=0 at a CLOCK_50 edge, any state):
  - state goes to IDLE.
  - All outputs go to 0, except rom_sel, which holds its last value.
  - In-flight pixels are discarded; no plot after reset.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - If start=1, latch img_sel, x0, y0, width and height.
  - If width=0 or height=0, go to DONE.
  - Otherwise go to FETCH, with col=0, row=0 and rom_addr=0 visible in the first FETCH cycle.
- FETCH:
  - Each cycle, rom_addr presents linear index row*width+col. It is generated by an incrementing counter, with no multiplier.
  - col increments each cycle. At col=width-1, col wraps to 0 and row increments.
  - After issuing the last address (row=height-1, col=width-1), go to DRAIN.
  - rom_addr is 16-bit and wraps modulo 65536.
- Pixel pipeline:
  - For the address presented in cycle t, rom_q is sampled in cycle t+ROM_LATENCY.
  - vga_x, vga_y, vga_colour and plot are registered and visible in cycle t+ROM_LATENCY+1.
  - A shift pipe of depth ROM_LATENCY carries col/row/valid alongside the ROM access.
- Coordinates:
  - X = x0+col is computed 10-bit; Y = y0+row is computed 9-bit.
  - plot=1 only if valid, X < SCREEN_W, Y < SCREEN_H, and not (TRANSP_EN and rom_q == TRANSP_COLOUR).
  - vga_x and vga_y carry the truncated X and Y even when plot=0.
- DRAIN: wait until the pipe is empty (ROM_LATENCY+1 cycles after the last address), then go to DONE.
- DONE:
  - done=1 for exactly one cycle, then IDLE.
  - done is asserted the cycle after the last possible plot.
- busy=1 in FETCH, DRAIN and DONE; 0 in IDLE.
- start outside IDLE is ignored. start held high re-triggers in the IDLE cycle after DONE.
- Latched inputs are stable for the whole draw; changes on x0/y0/width/height/img_sel while busy have no effect.
- Throughput: width*height + ROM_LATENCY + 3 cycles from start edge to the end of the done pulse; no bubbles between pixels.

Test Plan:
- Reset: hold reset=0 for 3 cycles with start=1 → plot=0, busy=0, done=0, rom_addr=0, vga_x=0, vga_y=0.
- 2x2 draw, origin (10,20), ROM_LATENCY=1, rom_q=addr+1:
  - rom_addr 0,1,2,3 on consecutive cycles from the cycle after start.
  - plot at (10,20,c1), (11,20,c2), (10,21,c3), (11,21,c4) on 4 consecutive cycles, starting 2 cycles after rom_addr=0.
  - done pulses the next cycle.
- Transparency: same 2x2, TRANSP_COLOUR=3'b000, rom_q=0 for addr 2 → plot low exactly in the (10,21) slot; other 3 plotted; done timing unchanged.
- Clipping: x0=318, y0=239, width=4, height=2 → rom_addr 0..7 all issued; plot only for (318,239) and (319,239); done after the full pipeline.
- Zero size: width=0, height=5, start=1 → no rom_addr change, no plot, busy=1 one cycle, done pulse in that same cycle.
- Reset mid-draw and start-while-busy:
  - start a 16x16 draw; pulse start again with new x0 at pixel 5 → ignored, coordinates unchanged.
  - assert reset at pixel 100 → next cycle plot=0, busy=0, no done pulse.
  - a fresh start then begins at rom_addr=0.
